fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/isa_shared.sv | 11 +
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_shared.sv
// Definitions shared across the ISA front end: reset vector default and fetch FSM states.
package isa_shared;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer holding fetched words tagged with their PC; head is shown combinationally.
module fetch_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      push,
    input  logic [DATA_WIDTH-1:0]     push_word,
    input  logic [DATA_WIDTH-1:0]     push_pc,
    input  logic                      pop,
    output logic                      head_valid,
    output logic [DATA_WIDTH-1:0]     head_word,
    output logic [DATA_WIDTH-1:0]     head_pc,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] word_mem [DEPTH];
    logic [DATA_WIDTH-1:0] pc_mem   [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_pop;

    always_comb begin
        head_valid = (count != '0);
        do_pop     = pop && head_valid;
        head_word  = head_valid ? word_mem[rd_ptr] : '0;
        head_pc    = head_valid ? pc_mem[rd_ptr]   : '0;
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            word_mem[wr_ptr] <= push_word;
            pc_mem[wr_ptr]   <= push_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited request stream, in-order response buffering, redirect with stale-response drain.
module fetch_unit
    import isa_shared::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT),
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [DATA_WIDTH-1:0] imem_resp_data,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [DATA_WIDTH-1:0] inst_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

    fetch_state_t          state;
    logic [DATA_WIDTH-1:0] fetch_pc;
    logic [DATA_WIDTH-1:0] resp_pc;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         drop_count;
    logic [CW-1:0]         fifo_count;

    logic                  handshake;
    logic                  push;
    logic                  pop;
    logic [CW:0]           credit_used;
    logic [CW-1:0]         outstanding_next;
    logic [DATA_WIDTH-1:0] redirect_target;

    // Buffered words plus in-flight requests may never exceed the buffer depth,
    // so every response always has a slot even without backpressure.
    always_comb begin
        credit_used      = {1'b0, fifo_count} + {1'b0, outstanding};
        imem_req_valid   = !rst && (state == RUN) && (credit_used < (CW+1)'(FIFO_DEPTH));
        imem_req_addr    = fetch_pc;
        handshake        = imem_req_valid && imem_req_ready;
        push             = imem_resp_valid && (state == RUN) && !redirect_valid;
        pop              = inst_valid && inst_ready && !redirect_valid;
        outstanding_next = outstanding + CW'(handshake) - CW'(imem_resp_valid);
        redirect_target  = redirect_pc & ~DATA_WIDTH'(3);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_count  <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old stream.
                fetch_pc   <= redirect_target;
                resp_pc    <= redirect_target;
                drop_count <= outstanding_next;
                state      <= (outstanding_next != '0) ? DRAIN : RUN;
            end else begin
                if (handshake) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (push) begin
                    resp_pc <= resp_pc + PC_STEP;
                end
                if (state == DRAIN && imem_resp_valid) begin
                    drop_count <= drop_count - CW'(1);
                    if (drop_count == CW'(1)) begin
                        state <= RUN;
                    end
                end
            end
        end
    end

    fetch_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (push),
        .push_word  (imem_resp_data),
        .push_pc    (resp_pc),
        .pop        (pop),
        .head_valid (inst_valid),
        .head_word  (inst_data),
        .head_pc    (inst_pc),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: in-order memory model, directed redirect cases and a randomized phase.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    fetch_unit #(
        .DATA_WIDTH (32),
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mem_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    mem_t        memq[$];
    exp_t        sbq[$];
    int unsigned cyc = 0;
    int unsigned lat = 1;
    int unsigned last_due = 0;
    logic [31:0] exp_fetch = RST_PC;
    int unsigned hs_count = 0;
    int unsigned pop_count = 0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory: answers handshaken requests in order, one per cycle, after lat cycles.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(memq[0].addr);
            void'(memq.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
    end

    // Monitor on the inactive edge: requests, deliveries, redirects.
    always @(negedge clk) begin
        if (rst) begin
            memq.delete();
            sbq.delete();
            last_due  = 0;
            exp_fetch = RST_PC;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                int unsigned due;
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                check_eq("req_addr", imem_req_addr, exp_fetch);
                memq.push_back('{addr: imem_req_addr, due: due});
                if (!redirect_valid) sbq.push_back('{pc: exp_fetch, data: mem_word(exp_fetch)});
                exp_fetch = exp_fetch + 32'd4;
                hs_count++;
            end
            if (inst_valid && inst_ready && !redirect_valid) begin
                pop_count++;
                check_eq("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
                if (sbq.size() != 0) begin
                    exp_t e;
                    e = sbq.pop_front();
                    check_eq("inst_pc", inst_pc, e.pc);
                    check_eq("inst_data", inst_data, e.data);
                end
            end
            if (redirect_valid) begin
                sbq.delete();
                exp_fetch = redirect_pc & ~32'd3;
            end
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int unsigned new_lat);
        rst = 1'b1;
        redirect_valid = 1'b0;
        lat = new_lat;
        step(3);
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
        check_eq("rst_inst_data", inst_data, 32'd0);
        check_eq("rst_inst_pc", inst_pc, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("first_req_valid", 32'(imem_req_valid), 32'd1);
        check_eq("first_req_addr", imem_req_addr, RST_PC);
    endtask

    task automatic wait_req(output int unsigned n);
        n = 0;
        while (!imem_req_valid && n < 40) begin
            step(1);
            n++;
        end
        if (!imem_req_valid) check_eq("wait_req_timeout", 32'(imem_req_valid), 32'd1);
    endtask

    initial begin
        int unsigned n;
        int unsigned snap;

        // Streaming with a 1-cycle memory: one instruction per cycle.
        inst_ready = 1'b1;
        imem_req_ready = 1'b1;
        do_reset(1);
        step(4);
        snap = pop_count;
        step(8);
        check_eq("stream_rate", pop_count - snap, 32'd8);

        // Decoder stalled: credits cap outstanding work at the buffer depth.
        inst_ready = 1'b0;
        do_reset(1);
        snap = hs_count;
        step(12);
        check_eq("stall_req_count", hs_count - snap, 32'd4);
        check_eq("stall_req_valid", 32'(imem_req_valid), 32'd0);
        inst_ready = 1'b1;
        wait_req(n);
        check_eq("resume_addr", imem_req_addr, 32'h0000_0010);
        step(10);

        // Redirect with three requests in flight.
        do_reset(5);
        step(2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        step(1);
        redirect_valid = 1'b0;
        check_eq("drain_req_valid", 32'(imem_req_valid), 32'd0);
        wait_req(n);
        check_eq("drain_len", n, 32'd5);
        check_eq("drain_next_addr", imem_req_addr, 32'h0000_0100);
        snap = pop_count;
        step(12);
        check_eq("after_drain_delivered", 32'(pop_count != snap), 32'd1);

        // Redirect to an unaligned target coincident with a response and a handshake.
        do_reset(1);
        step(6);
        check_eq("coincide_req_valid", 32'(imem_req_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0203;
        step(1);
        redirect_valid = 1'b0;
        check_eq("flush_inst_valid", 32'(inst_valid), 32'd0);
        wait_req(n);
        check_eq("coincide_drain_len", n, 32'd1);
        check_eq("aligned_addr", imem_req_addr, 32'h0000_0200);
        step(8);

        // Second redirect during DRAIN: latest target wins.
        do_reset(5);
        step(1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        step(1);
        redirect_pc = 32'h0000_0400;
        step(1);
        redirect_valid = 1'b0;
        wait_req(n);
        check_eq("drain2_len", n, 32'd4);
        check_eq("drain2_addr", imem_req_addr, 32'h0000_0400);
        step(14);

        // Address wrap at the top of the space.
        do_reset(1);
        step(3);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step(1);
        redirect_valid = 1'b0;
        wait_req(n);
        check_eq("wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
        step(1);
        check_eq("wrap_addr1", imem_req_addr, 32'h0000_0000);
        step(8);

        // Randomized traffic with redirects and a mid-run reset.
        do_reset(2);
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) lat = $urandom_range(1, 4);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 3) != 0);
            redirect_pc    = $urandom;
            redirect_valid = ($urandom_range(0, 24) == 0);
            if (i == 200 || i == 201) begin
                rst = 1'b1;
                redirect_valid = 1'b0;
            end else begin
                rst = 1'b0;
            end
            step(1);
        end
        rst = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        step(20);
        snap = pop_count;
        step(10);
        check_eq("final_rate", 32'(pop_count - snap >= 8), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
